edge_bbox_scanner: RTL and testbench

//  Reader side of the edge-map BRAM written by the Sobel stage. After Sobel

---
 rtl/edge_bbox_scanner_if.sv | 38 +++
 rtl/edge_bbox_scanner.sv | 160 ++++++++++++++++
 tb/tb_edge_bbox_scanner.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_bbox_scanner_if.sv
// Bus between the edge-map scanner, its edge BRAM and the downstream consumer.
// EDGE_CENTROID_EN adds the sum_x/sum_y centroid accumulators.
interface edge_bbox_scanner_if;
    logic        start;
    logic        done;
    logic [18:0] edge_memory_addr;
    logic [3:0]  edge_data;
    logic        found;
    logic [9:0]  x_min;
    logic [9:0]  x_max;
    logic [8:0]  y_min;
    logic [8:0]  y_max;
    logic [18:0] edge_count;
`ifdef EDGE_CENTROID_EN
    logic [27:0] sum_x;
    logic [27:0] sum_y;

    modport master (
        input  start, edge_data,
        output done, edge_memory_addr, found, x_min, x_max, y_min, y_max, edge_count,
        output sum_x, sum_y
    );
    modport slave (
        output start, edge_data,
        input  done, edge_memory_addr, found, x_min, x_max, y_min, y_max, edge_count,
        input  sum_x, sum_y
    );
`else
    modport master (
        input  start, edge_data,
        output done, edge_memory_addr, found, x_min, x_max, y_min, y_max, edge_count
    );
    modport slave (
        output start, edge_data,
        input  done, edge_memory_addr, found, x_min, x_max, y_min, y_max, edge_count
    );
`endif
endinterface

// File: rtl/edge_bbox_scanner.sv
// Raster-scans the edge BRAM once per start and reports edge count and bounding box.
// Optional EDGE_CENTROID_EN also accumulates x/y sums of edge pixels.
module edge_bbox_scanner #(
    parameter int unsigned WIDTH        = 640,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    edge_bbox_scanner_if.master bus
);
    localparam logic [18:0] LastAddr = 19'(WIDTH * HEIGHT - 1);
    localparam logic [9:0]  LastX    = 10'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e                  state_q;
    logic                    done_q;
    logic [18:0]             addr_q;
    logic [9:0]              x_q;
    logic [8:0]              y_q;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [9:0]              pipe_x_q [READ_LATENCY];
    logic [8:0]              pipe_y_q [READ_LATENCY];
    logic                    found_q;
    logic [9:0]              x_min_q, x_max_q;
    logic [8:0]              y_min_q, y_max_q;
    logic [18:0]             count_q;
`ifdef EDGE_CENTROID_EN
    logic [27:0]             sum_x_q, sum_y_q;
`endif

    logic       issue, hit, unused_data;
    logic [9:0] hit_x;
    logic [8:0] hit_y;

    // A dropped start flushes the pipe, so in-flight reads are never sampled.
    assign issue       = (state_q == StScan) && bus.start;
    assign hit         = pipe_vld_q[READ_LATENCY-1] && bus.edge_data[0] && bus.start;
    assign hit_x       = pipe_x_q[READ_LATENCY-1];
    assign hit_y       = pipe_y_q[READ_LATENCY-1];
    assign unused_data = ^bus.edge_data[3:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            addr_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_x_q[i] <= '0;
                pipe_y_q[i] <= '0;
            end
            found_q    <= 1'b0;
            x_min_q    <= '0;
            x_max_q    <= '0;
            y_min_q    <= '0;
            y_max_q    <= '0;
            count_q    <= '0;
`ifdef EDGE_CENTROID_EN
            sum_x_q    <= '0;
            sum_y_q    <= '0;
`endif
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_x_q[i]   <= pipe_x_q[i-1];
                pipe_y_q[i]   <= pipe_y_q[i-1];
            end
            pipe_vld_q[0] <= issue;
            pipe_x_q[0]   <= x_q;
            pipe_y_q[0]   <= y_q;

            if (hit) begin
                found_q <= 1'b1;
                count_q <= count_q + 19'd1;
`ifdef EDGE_CENTROID_EN
                sum_x_q <= sum_x_q + 28'(hit_x);
                sum_y_q <= sum_y_q + 28'(hit_y);
`endif
                if (!found_q) begin
                    x_min_q <= hit_x;
                    x_max_q <= hit_x;
                    y_min_q <= hit_y;
                    y_max_q <= hit_y;
                end else begin
                    if (hit_x < x_min_q) x_min_q <= hit_x;
                    if (hit_x > x_max_q) x_max_q <= hit_x;
                    if (hit_y < y_min_q) y_min_q <= hit_y;
                    if (hit_y > y_max_q) y_max_q <= hit_y;
                end
            end

            case (state_q)
                StIdle: begin
                    // Pipe is empty in IDLE, so clearing cannot race a sample.
                    if (bus.start) begin
                        state_q <= StScan;
                        addr_q  <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        found_q <= 1'b0;
                        x_min_q <= '0;
                        x_max_q <= '0;
                        y_min_q <= '0;
                        y_max_q <= '0;
                        count_q <= '0;
`ifdef EDGE_CENTROID_EN
                        sum_x_q <= '0;
                        sum_y_q <= '0;
`endif
                    end
                end
                StScan: begin
                    if (addr_q == LastAddr) begin
                        state_q <= StDrain;
                    end else begin
                        addr_q <= addr_q + 19'd1;
                        if (x_q == LastX) begin
                            x_q <= '0;
                            y_q <= y_q + 9'd1;
                        end else begin
                            x_q <= x_q + 10'd1;
                        end
                    end
                end
                StDrain: begin
                    if (pipe_vld_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: ;
                default: state_q <= StIdle;
            endcase

            if (!bus.start) begin
                state_q    <= StIdle;
                done_q     <= 1'b0;
                addr_q     <= '0;
                pipe_vld_q <= '0;
            end
        end
    end

    assign bus.done             = done_q;
    assign bus.edge_memory_addr = addr_q;
    assign bus.found            = found_q;
    assign bus.x_min            = x_min_q;
    assign bus.x_max            = x_max_q;
    assign bus.y_min            = y_min_q;
    assign bus.y_max            = y_max_q;
    assign bus.edge_count       = count_q;
`ifdef EDGE_CENTROID_EN
    assign bus.sum_x            = sum_x_q;
    assign bus.sum_y            = sum_y_q;
`endif
endmodule

// File: tb/tb_edge_bbox_scanner.sv
// Directed bench for edge_bbox_scanner on an 8x4 frame with a 2-clock model BRAM.
module tb_edge_bbox_scanner;
    logic clk;
    logic rst;
    logic start_r;
    logic [3:0]  mem [32];
    logic [18:0] addr_r;
    logic [3:0]  rd_q;
    int checks;
    int errors;

    edge_bbox_scanner_if bus();

    assign bus.start     = start_r;
    assign bus.edge_data = rd_q;

    edge_bbox_scanner #(
        .WIDTH        (8),
        .HEIGHT       (4),
        .READ_LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-clock BRAM: address registered, then data registered.
    always @(posedge clk) begin
        addr_r <= bus.edge_memory_addr;
        rd_q   <= mem[addr_r[4:0]];
    end

    task automatic fill(input logic [3:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    // Raise start, then count clocks from the first edge seeing it until done.
    task automatic scan(output int lat);
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic stop_scan;
        @(negedge clk);
        start_r = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({bus.done, bus.found, bus.edge_memory_addr, bus.x_min, bus.x_max, bus.y_min,
             bus.y_max, bus.edge_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b found=%b addr=%0d count=%0d want all 0",
                     bus.done, bus.found, bus.edge_memory_addr, bus.edge_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_all_zero;
        int lat;
        fill(4'h0);
        scan(lat);
        checks++;
        if (lat !== 35) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 35", lat);
        end
        checks++;
        if (bus.found !== 1'b0 || bus.edge_count !== 19'd0) begin
            errors++;
            $display("FAIL zero_count: found=%b count=%0d want 0/0", bus.found, bus.edge_count);
        end
        checks++;
        if ({bus.x_min, bus.x_max, bus.y_min, bus.y_max} !== 38'd0) begin
            errors++;
            $display("FAIL zero_box: %0d %0d %0d %0d want 0 0 0 0",
                     bus.x_min, bus.x_max, bus.y_min, bus.y_max);
        end
        checks++;
        if (bus.edge_memory_addr !== 19'd31) begin
            errors++;
            $display("FAIL done_addr_hold: got %0d want 31", bus.edge_memory_addr);
        end
        stop_scan();
        checks++;
        if (bus.done !== 1'b0 || bus.edge_memory_addr !== 19'd0) begin
            errors++;
            $display("FAIL stop_clear: done=%b addr=%0d want 0/0", bus.done, bus.edge_memory_addr);
        end
    endtask

    task automatic test_single_edge;
        int lat;
        fill(4'h0);
        mem[21] = 4'h1;
        scan(lat);
        checks++;
        if (lat !== 35) begin
            errors++;
            $display("FAIL single_latency: got %0d want 35", lat);
        end
        checks++;
        if (bus.found !== 1'b1 || bus.edge_count !== 19'd1) begin
            errors++;
            $display("FAIL single_count: found=%b count=%0d want 1/1", bus.found, bus.edge_count);
        end
        checks++;
        if (bus.x_min !== 10'd5 || bus.x_max !== 10'd5 || bus.y_min !== 9'd2
            || bus.y_max !== 9'd2) begin
            errors++;
            $display("FAIL single_box: %0d %0d %0d %0d want 5 5 2 2",
                     bus.x_min, bus.x_max, bus.y_min, bus.y_max);
        end
`ifdef EDGE_CENTROID_EN
        checks++;
        if (bus.sum_x !== 28'd5 || bus.sum_y !== 28'd2) begin
            errors++;
            $display("FAIL single_sums: %0d %0d want 5 2", bus.sum_x, bus.sum_y);
        end
`endif
        stop_scan();
    endtask

    task automatic test_corners;
        int lat;
        fill(4'b1110);
        mem[0]  = 4'h1;
        mem[31] = 4'h1;
        scan(lat);
        checks++;
        if (bus.edge_count !== 19'd2 || bus.found !== 1'b1) begin
            errors++;
            $display("FAIL corner_count: count=%0d found=%b want 2/1", bus.edge_count, bus.found);
        end
        checks++;
        if (bus.x_min !== 10'd0 || bus.x_max !== 10'd7 || bus.y_min !== 9'd0
            || bus.y_max !== 9'd3) begin
            errors++;
            $display("FAIL corner_box: %0d %0d %0d %0d want 0 7 0 3",
                     bus.x_min, bus.x_max, bus.y_min, bus.y_max);
        end
`ifdef EDGE_CENTROID_EN
        checks++;
        if (bus.sum_x !== 28'd7 || bus.sum_y !== 28'd3) begin
            errors++;
            $display("FAIL corner_sums: %0d %0d want 7 3", bus.sum_x, bus.sum_y);
        end
`endif
        stop_scan();
    endtask

    task automatic test_all_ones;
        int lat;
        fill(4'hF);
        scan(lat);
        checks++;
        if (lat !== 35) begin
            errors++;
            $display("FAIL ones_latency: got %0d want 35", lat);
        end
        checks++;
        if (bus.edge_count !== 19'd32) begin
            errors++;
            $display("FAIL ones_count: got %0d want 32", bus.edge_count);
        end
        checks++;
        if (bus.x_min !== 10'd0 || bus.x_max !== 10'd7 || bus.y_min !== 9'd0
            || bus.y_max !== 9'd3) begin
            errors++;
            $display("FAIL ones_box: %0d %0d %0d %0d want 0 7 0 3",
                     bus.x_min, bus.x_max, bus.y_min, bus.y_max);
        end
`ifdef EDGE_CENTROID_EN
        checks++;
        if (bus.sum_x !== 28'd112 || bus.sum_y !== 28'd48) begin
            errors++;
            $display("FAIL ones_sums: %0d %0d want 112 48", bus.sum_x, bus.sum_y);
        end
`endif
        stop_scan();
    endtask

    task automatic test_abort_restart;
        int lat;
        fill(4'b1110);
        mem[0]  = 4'h1;
        mem[31] = 4'h1;
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.edge_memory_addr !== 19'd10) begin
            errors++;
            $display("FAIL abort_mid_addr: got %0d want 10", bus.edge_memory_addr);
        end
        stop_scan();
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.edge_memory_addr !== 19'd0) begin
            errors++;
            $display("FAIL abort_idle: done=%b addr=%0d want 0/0", bus.done, bus.edge_memory_addr);
        end
        scan(lat);
        checks++;
        if (lat !== 35) begin
            errors++;
            $display("FAIL restart_latency: got %0d want 35", lat);
        end
        checks++;
        if (bus.edge_count !== 19'd2 || bus.x_min !== 10'd0 || bus.x_max !== 10'd7
            || bus.y_min !== 9'd0 || bus.y_max !== 9'd3) begin
            errors++;
            $display("FAIL restart_result: count=%0d box %0d %0d %0d %0d want 2, 0 7 0 3",
                     bus.edge_count, bus.x_min, bus.x_max, bus.y_min, bus.y_max);
        end
        stop_scan();
    endtask

    task automatic test_async_reset;
        int lat;
        fill(4'hF);
        @(negedge clk);
        start_r = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        // Samples land at edges 3..20 -> addresses 0..17.
        checks++;
        if (bus.edge_count !== 19'd18 || bus.y_max !== 9'd2) begin
            errors++;
            $display("FAIL midscan_progress: count=%0d y_max=%0d want 18/2",
                     bus.edge_count, bus.y_max);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.done, bus.found, bus.edge_memory_addr, bus.x_min, bus.x_max, bus.y_min,
             bus.y_max, bus.edge_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: found=%b addr=%0d count=%0d x_max=%0d want all 0",
                     bus.found, bus.edge_memory_addr, bus.edge_count, bus.x_max);
        end
        @(negedge clk);
        start_r = 1'b0;
        rst     = 1'b0;
        scan(lat);
        checks++;
        if (lat !== 35 || bus.edge_count !== 19'd32) begin
            errors++;
            $display("FAIL post_reset_scan: lat=%0d count=%0d want 35/32", lat, bus.edge_count);
        end
        stop_scan();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start_r = 1'b0;
        fill(4'h0);
        test_reset();
        test_all_zero();
        test_single_edge();
        test_corners();
        test_all_ones();
        test_abort_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
